// File: rtl/dest_tag_issuer.sv
// Master-side tag issuer: hands out tags from a free-list FIFO, records dest/vc per tag,
// and on reply looks the tag up, returns dest/vc and recycles the tag at the free-list tail.
module dest_tag_issuer #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_TAG        = 8,
  parameter int NUM_TAGS         = 16
) (
  input  logic                              clk,
  input  logic                              preset_full,
  input  logic                              i_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]          i_req_dst,
  input  logic [VC_ADDRESS_WIDTH-1:0]       i_req_vc,
  output logic                              i_req_ready,
  output logic [WIDTH_TAG-1:0]              o_req_tag,
  input  logic                              i_rsp_valid,
  input  logic [WIDTH_TAG-1:0]              i_rsp_tag,
  output logic                              o_rsp_valid,
  output logic [ADDRESS_WIDTH-1:0]          o_rsp_dst,
  output logic [VC_ADDRESS_WIDTH-1:0]       o_rsp_vc,
  output logic                              o_rsp_err,
  output logic [$clog2(NUM_TAGS+1)-1:0]     o_outstanding,
  output logic                              o_idle
);

  localparam int IDX_W = $clog2(NUM_TAGS);
  localparam int CNT_W = $clog2(NUM_TAGS+1);

  // Request handshake: a tag is allocated on any cycle where i_req_valid && i_req_ready;
  // i_req_ready depends only on registered state, never on i_req_valid.
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            init_idx_q, init_idx_d;
  logic [IDX_W-1:0]            head_q, head_d;
  logic [IDX_W-1:0]            tail_q, tail_d;
  logic [CNT_W-1:0]            free_cnt_q, free_cnt_d;
  logic [CNT_W-1:0]            out_cnt_q, out_cnt_d;
  logic [NUM_TAGS-1:0]         busy_q, busy_d;
  logic [IDX_W-1:0]            fl_q [NUM_TAGS];
  logic [IDX_W-1:0]            fl_d [NUM_TAGS];
  logic [ADDRESS_WIDTH-1:0]    tbl_dst_q [NUM_TAGS];
  logic [ADDRESS_WIDTH-1:0]    tbl_dst_d [NUM_TAGS];
  logic [VC_ADDRESS_WIDTH-1:0] tbl_vc_q [NUM_TAGS];
  logic [VC_ADDRESS_WIDTH-1:0] tbl_vc_d [NUM_TAGS];
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_err_q, rsp_err_d;
  logic [ADDRESS_WIDTH-1:0]    rsp_dst_q, rsp_dst_d;
  logic [VC_ADDRESS_WIDTH-1:0] rsp_vc_q, rsp_vc_d;

  logic             run;
  logic             alloc;
  logic             rsp_in_range;
  logic             rsp_ok;
  logic             rsp_bad;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] rsp_idx;

  assign run          = (state_q == ST_RUN);
  assign i_req_ready  = run && (free_cnt_q != '0);
  assign alloc_idx    = fl_q[head_q];
  assign o_req_tag    = run ? WIDTH_TAG'(alloc_idx) : '0;
  assign alloc        = i_req_valid && i_req_ready;
  assign rsp_idx      = i_rsp_tag[IDX_W-1:0];
  // Widened by one bit so NUM_TAGS == 2**WIDTH_TAG still compares correctly.
  assign rsp_in_range = {1'b0, i_rsp_tag} < (WIDTH_TAG+1)'(NUM_TAGS);
  assign rsp_ok       = run && i_rsp_valid && rsp_in_range && busy_q[rsp_idx];
  assign rsp_bad      = run && i_rsp_valid && !rsp_ok;

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rsp_dst     = rsp_dst_q;
  assign o_rsp_vc      = rsp_vc_q;
  assign o_outstanding = out_cnt_q;
  assign o_idle        = run && (out_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    head_d      = head_q;
    tail_d      = tail_q;
    free_cnt_d  = free_cnt_q;
    out_cnt_d   = out_cnt_q;
    busy_d      = busy_q;
    fl_d        = fl_q;
    tbl_dst_d   = tbl_dst_q;
    tbl_vc_d    = tbl_vc_q;
    rsp_valid_d = rsp_ok;
    rsp_err_d   = rsp_bad;
    rsp_dst_d   = rsp_dst_q;
    rsp_vc_d    = rsp_vc_q;

    case (state_q)
      ST_INIT: begin
        fl_d[init_idx_q] = init_idx_q;
        init_idx_d       = init_idx_q + 1'b1;
        if (init_idx_q == IDX_W'(NUM_TAGS-1)) begin
          state_d    = ST_RUN;
          free_cnt_d = CNT_W'(NUM_TAGS);
          head_d     = '0;
          tail_d     = '0;
        end
      end
      default: begin
        // Reply is evaluated against registered busy, so a same-cycle alloc cannot alias it.
        if (rsp_ok) begin
          rsp_dst_d       = tbl_dst_q[rsp_idx];
          rsp_vc_d        = tbl_vc_q[rsp_idx];
          busy_d[rsp_idx] = 1'b0;
          fl_d[tail_q]    = rsp_idx;
          tail_d          = tail_q + 1'b1;
        end
        if (alloc) begin
          tbl_dst_d[alloc_idx] = i_req_dst;
          tbl_vc_d[alloc_idx]  = i_req_vc;
          busy_d[alloc_idx]    = 1'b1;
          head_d               = head_q + 1'b1;
        end
        free_cnt_d = free_cnt_q + CNT_W'(rsp_ok) - CNT_W'(alloc);
        out_cnt_d  = out_cnt_q + CNT_W'(alloc) - CNT_W'(rsp_ok);
      end
    endcase
  end

  always_ff @(posedge clk or posedge preset_full) begin
    if (preset_full) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      free_cnt_q  <= '0;
      out_cnt_q   <= '0;
      busy_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dst_q   <= '0;
      rsp_vc_q    <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        fl_q[i]      <= '0;
        tbl_dst_q[i] <= '0;
        tbl_vc_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      free_cnt_q  <= free_cnt_d;
      out_cnt_q   <= out_cnt_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dst_q   <= rsp_dst_d;
      rsp_vc_q    <= rsp_vc_d;
      fl_q        <= fl_d;
      tbl_dst_q   <= tbl_dst_d;
      tbl_vc_q    <= tbl_vc_d;
    end
  end

  // Free-list underflow must be unreachable.
  a_no_underflow: assert property (@(posedge clk) disable iff (preset_full)
    alloc |-> (free_cnt_q != '0));

endmodule

// File: tb/tb_dest_tag_issuer.sv
// Bench for dest_tag_issuer: a reference model of the free list and tag table predicts
// every grant, count and reply; replies go through an expected queue checked one cycle later.
module tb_dest_tag_issuer;

  localparam int AW = 4;
  localparam int VW = 1;
  localparam int TW = 8;
  localparam int NT = 16;

  logic          clk = 1'b0;
  logic          preset_full = 1'b0;
  logic          i_req_valid = 1'b0;
  logic [AW-1:0] i_req_dst = '0;
  logic [VW-1:0] i_req_vc = '0;
  logic          i_req_ready;
  logic [TW-1:0] o_req_tag;
  logic          i_rsp_valid = 1'b0;
  logic [TW-1:0] i_rsp_tag = '0;
  logic          o_rsp_valid;
  logic [AW-1:0] o_rsp_dst;
  logic [VW-1:0] o_rsp_vc;
  logic          o_rsp_err;
  logic [4:0]    o_outstanding;
  logic          o_idle;

  always #5 clk = ~clk;

  dest_tag_issuer #(
    .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .WIDTH_TAG(TW), .NUM_TAGS(NT)
  ) dut (
    .clk(clk), .preset_full(preset_full),
    .i_req_valid(i_req_valid), .i_req_dst(i_req_dst), .i_req_vc(i_req_vc),
    .i_req_ready(i_req_ready), .o_req_tag(o_req_tag),
    .i_rsp_valid(i_rsp_valid), .i_rsp_tag(i_rsp_tag),
    .o_rsp_valid(o_rsp_valid), .o_rsp_dst(o_rsp_dst), .o_rsp_vc(o_rsp_vc),
    .o_rsp_err(o_rsp_err), .o_outstanding(o_outstanding), .o_idle(o_idle)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Expected reply entry: {err, valid, dst[3:0], vc}.
  logic [6:0] exp_q[$];

  bit            run_m;
  int            init_m;
  int            fl_m[$];
  bit            busy_m[NT];
  logic [AW-1:0] dst_m[NT];
  logic [VW-1:0] vc_m[NT];
  int            out_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    run_m  = 1'b0;
    init_m = 0;
    fl_m.delete();
    for (int i = 0; i < NT; i++) busy_m[i] = 1'b0;
    out_m = 0;
    exp_q.delete();
  endtask

  // Called at a negedge; asserts reset, checks outputs clear asynchronously, releases at next negedge.
  task automatic do_reset();
    preset_full = 1'b1;
    i_req_valid = 1'b0;
    i_rsp_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", i_req_ready, 0);
    chk("rst_tag", o_req_tag, 0);
    chk("rst_outstanding", o_outstanding, 0);
    chk("rst_idle", o_idle, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_err", o_rsp_err, 0);
    chk("rst_rsp_dst", o_rsp_dst, 0);
    chk("rst_rsp_vc", o_rsp_vc, 0);
    @(negedge clk);
    preset_full = 1'b0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cycle(input bit rv, input logic [AW-1:0] d, input logic [VW-1:0] v,
                       input bit pv, input logic [TW-1:0] t);
    bit         rdy;
    bit         ok;
    int         tg;
    logic [6:0] e;
    rdy = run_m && (fl_m.size() > 0);
    chk("ready", i_req_ready, rdy);
    if (rdy) chk("req_tag", o_req_tag, fl_m[0]);
    chk("outstanding", o_outstanding, out_m);
    chk("idle", o_idle, run_m && (out_m == 0));

    i_req_valid = rv;
    i_req_dst   = d;
    i_req_vc    = v;
    i_rsp_valid = pv;
    i_rsp_tag   = t;

    if (!run_m) begin
      init_m++;
      if (init_m == NT) begin
        run_m = 1'b1;
        for (int i = 0; i < NT; i++) fl_m.push_back(i);
      end
    end else begin
      ok = pv && (int'(t) < NT) && busy_m[int'(t)];
      if (rv && rdy) begin
        tg = fl_m.pop_front();
        busy_m[tg] = 1'b1;
        dst_m[tg]  = d;
        vc_m[tg]   = v;
        out_m++;
      end
      if (ok) begin
        tg = int'(t);
        exp_q.push_back({2'b01, dst_m[tg], vc_m[tg]});
        busy_m[tg] = 1'b0;
        fl_m.push_back(tg);
        out_m--;
      end else if (pv) begin
        exp_q.push_back(7'b10_0000_0);
      end
    end

    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    i_rsp_valid = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_err", o_rsp_err, e[6]);
      chk("rsp_valid", o_rsp_valid, e[5]);
      if (e[5]) begin
        chk("rsp_dst", o_rsp_dst, e[4:1]);
        chk("rsp_vc", o_rsp_vc, e[0]);
      end
    end else begin
      chk("rsp_quiet", {o_rsp_err, o_rsp_valid}, 0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset and init sweep, then idle run state with tag 0 at the head.
    do_reset();
    idle_cycles(NT);
    idle_cycles(2);

    // Three allocations, then reply of tag 1.
    cycle(1, 4'd3, 1'b0, 0, '0);
    cycle(1, 4'd5, 1'b1, 0, '0);
    cycle(1, 4'd7, 1'b0, 0, '0);
    cycle(0, '0, '0, 1, 8'd1);
    idle_cycles(1);

    // Fresh pool: drain all 16, then release tag 9 and watch it come back.
    do_reset();
    idle_cycles(NT);
    for (int i = 0; i < NT; i++) cycle(1, AW'(15 - i), VW'(i), 0, '0);
    cycle(1, 4'd1, 1'b1, 0, '0);
    cycle(0, '0, '0, 1, 8'd9);
    // Alloc tag 9 while replying tag 4; tag 4 then heads the free list.
    cycle(1, 4'd12, 1'b1, 1, 8'd4);
    cycle(1, 4'd6, 1'b0, 0, '0);
    idle_cycles(1);

    // Error replies: tag 2 freed then replied again, and an out-of-range tag.
    cycle(0, '0, '0, 1, 8'd2);
    cycle(0, '0, '0, 1, 8'd2);
    cycle(0, '0, '0, 1, 8'd20);
    cycle(0, '0, '0, 1, 8'd255);
    idle_cycles(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 6, AW'($urandom_range(0, 15)), VW'($urandom_range(0, 1)),
            $urandom_range(0, 1) == 1, TW'($urandom_range(0, 19)));
    end
    idle_cycles(2);

    // Reset with five tags outstanding and a non-zero held reply.
    do_reset();
    idle_cycles(NT);
    for (int i = 0; i < 6; i++) cycle(1, AW'(i + 9), 1'b1, 0, '0);
    cycle(0, '0, '0, 1, 8'd3);
    chk("pre_reset_outstanding", o_outstanding, 5);
    do_reset();
    idle_cycles(NT);
    cycle(1, 4'd2, 1'b0, 0, '0);
    cycle(0, '0, '0, 1, 8'd0);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
